// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared state encoding, default width and counter sizing for the multiplier controller
package seq_mul_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_mul_if.sv
// seq_mul_if: control bundle between the multiplier controller (slave) and its requester/datapath (master); abort exists only with SEQ_MUL_ABORT_EN
interface seq_mul_if import seq_mul_pkg::*; #(parameter int WIDTH = DEF_WIDTH);

    logic                    start;
    logic                    mplr_lsb;
    logic                    load;
    logic                    add_en;
    logic                    shift_en;
    logic                    busy;
    logic                    done;
    logic [cnt_w(WIDTH)-1:0] bit_cnt;

`ifdef SEQ_MUL_ABORT_EN
    logic                    abort;

    modport slave (
        input  start, mplr_lsb, abort,
        output load, add_en, shift_en, busy, done, bit_cnt
    );

    modport master (
        output start, mplr_lsb, abort,
        input  load, add_en, shift_en, busy, done, bit_cnt
    );
`else
    modport slave (
        input  start, mplr_lsb,
        output load, add_en, shift_en, busy, done, bit_cnt
    );

    modport master (
        output start, mplr_lsb,
        input  load, add_en, shift_en, busy, done, bit_cnt
    );
`endif

endinterface

// File: rtl/seq_mul_ctrl.sv
// seq_mul_ctrl: Moore FSM sequencing a shift-add multiplier datapath; SEQ_MUL_ABORT_EN adds an abort input
module seq_mul_ctrl
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic     clk,
    input  logic     reset,
    seq_mul_if.slave bus
);

    localparam int             CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic          abort_hit;

`ifdef SEQ_MUL_ABORT_EN
    assign abort_hit = bus.abort && (state inside {LOAD, TEST, ADD, SHIFT});
`else
    assign abort_hit = 1'b0;
`endif

    // state register, forced to IDLE by the asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    // shift counter: cleared in LOAD, saturates at WIDTH-1 so it never wraps, frozen on abort
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                     cnt <= '0;
        else if (abort_hit)                             cnt <= cnt;
        else if (state == LOAD)                         cnt <= '0;
        else if (state == SHIFT && cnt != LAST)         cnt <= cnt + 1'b1;
    end

    // next-state decode; abort overrides every other transition
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.start ? LOAD : IDLE;
            LOAD:    nxt = TEST;
            TEST:    nxt = bus.mplr_lsb ? ADD : SHIFT;
            ADD:     nxt = SHIFT;
            SHIFT:   nxt = (cnt == LAST) ? DONE : TEST;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort_hit) nxt = IDLE;
    end

    assign bus.load     = (state == LOAD);
    assign bus.add_en   = (state == ADD);
    assign bus.shift_en = (state == SHIFT);
    assign bus.busy     = state inside {LOAD, TEST, ADD, SHIFT};
    assign bus.done     = (state == DONE);
    assign bus.bit_cnt  = cnt;

endmodule
